// File: rtl/object_capture.sv
`default_nettype none
// ============================================================================
// Module  : object_capture
// Purpose : Snoops the pixel-plot bus and captures a 16x16 window into a
//           256x24 object memory with arm/busy/done handshake and readback.
// Revision: 1.0 - initial release
// ============================================================================
module object_capture #(
  parameter int n       = 8,
  parameter int XOFFSET = 72,
  parameter int YOFFSET = 52
) (
  input  logic          CLOCK_50,
  input  logic          Resetn,
  input  logic [n-1:0]  VGA_X,
  input  logic [n-2:0]  VGA_Y,
  input  logic [23:0]   VGA_COLOR,
  input  logic          plot,
  input  logic          arm,
  input  logic [7:0]    rd_address,
  output logic [23:0]   rd_data,
  output logic          busy,
  output logic          done,
  output logic [8:0]    count
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  localparam int         X_HI_I = XOFFSET + 16;
  localparam int         Y_HI_I = YOFFSET + 16;
  localparam logic [n:0] X_LO   = XOFFSET[n:0];
  localparam logic [n:0] X_HI   = X_HI_I[n:0];
  localparam logic [n:0] Y_LO   = YOFFSET[n:0];
  localparam logic [n:0] Y_HI   = Y_HI_I[n:0];

  logic [1:0]   state;
  logic [1:0]   state_next;
  logic [255:0] written;
  logic         s1_valid;
  logic [7:0]   s1_addr;
  logic [23:0]  s1_color;
  logic [23:0]  mem [0:255];

  logic [n:0]   x_ext;
  logic [n:0]   y_ext;
  logic         inwin;
  logic         accept;
  logic [3:0]   lx;
  logic [3:0]   ly;
  logic         new_addr;

  // Window compare one bit wider than the bus so XOFFSET+16 cannot wrap.
  assign x_ext    = {1'b0, VGA_X};
  assign y_ext    = {2'b00, VGA_Y};
  assign inwin    = (x_ext >= X_LO) && (x_ext < X_HI) &&
                    (y_ext >= Y_LO) && (y_ext < Y_HI);
  assign lx       = VGA_X[3:0] - X_LO[3:0];
  assign ly       = VGA_Y[3:0] - Y_LO[3:0];
  assign accept   = plot && inwin && (state == CAPTURE) && !arm;
  assign new_addr = s1_valid && !written[s1_addr];

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (arm) state_next = CAPTURE;
      CAPTURE: if (arm) state_next = CAPTURE;
               else if (new_addr && (count == 9'd255)) state_next = DONE;
      DONE:    if (arm) state_next = CAPTURE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CAPTURE);
    done = (state == DONE);
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      s1_valid <= 1'b0;
      s1_addr  <= 8'd0;
      s1_color <= 24'd0;
    end else begin
      s1_valid <= accept;
      s1_addr  <= {ly, lx};
      s1_color <= VGA_COLOR;
    end
  end

  // Arm clears map/count with priority over a write landing the same edge.
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      written <= '0;
      count   <= 9'd0;
    end else if (arm) begin
      written <= '0;
      count   <= 9'd0;
    end else if (new_addr) begin
      written[s1_addr] <= 1'b1;
      count            <= count + 9'd1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (s1_valid) mem[s1_addr] <= s1_color;
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) rd_data <= 24'd0;
    else         rd_data <= mem[rd_address];
  end

endmodule
`default_nettype wire

// File: tb/tb_object_capture.sv
`default_nettype none
// ============================================================================
// Module  : tb_object_capture
// Purpose : Directed self-checking bench for object_capture.
// Revision: 1.0 - initial release
// ============================================================================
module tb_object_capture;

  logic        CLOCK_50 = 1'b0;
  logic        Resetn;
  logic [7:0]  VGA_X;
  logic [6:0]  VGA_Y;
  logic [23:0] VGA_COLOR;
  logic        plot;
  logic        arm;
  logic [7:0]  rd_address;
  logic [23:0] rd_data;
  logic        busy;
  logic        done;
  logic [8:0]  count;

  int n_vec = 0;
  int n_err = 0;

  object_capture #(.n(8), .XOFFSET(72), .YOFFSET(52)) dut (
    .CLOCK_50  (CLOCK_50),
    .Resetn    (Resetn),
    .VGA_X     (VGA_X),
    .VGA_Y     (VGA_Y),
    .VGA_COLOR (VGA_COLOR),
    .plot      (plot),
    .arm       (arm),
    .rd_address(rd_address),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .count     (count)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic drive(input int x, input int y, input logic [23:0] c);
    VGA_X     = 8'(x);
    VGA_Y     = 7'(y);
    VGA_COLOR = c;
    plot      = 1'b1;
    tick();
    plot      = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [23:0] exp);
    rd_address = a;
    tick();
    chk(tag, {8'h0, rd_data}, {8'h0, exp});
  endtask

  initial begin
    Resetn = 1'b0; VGA_X = '0; VGA_Y = '0; VGA_COLOR = '0;
    plot = 1'b0; arm = 1'b0; rd_address = '0;
    tick(); tick();
    chk("rst_busy",  {31'h0, busy}, 32'd0);
    chk("rst_done",  {31'h0, done}, 32'd0);
    chk("rst_count", {23'h0, count}, 32'd0);
    chk("rst_rd",    {8'h0, rd_data}, 32'd0);
    Resetn = 1'b1;
    tick();

    // Plot without arm is ignored in IDLE
    drive(72, 52, 24'h777777); tick();
    chk("idle_count", {23'h0, count}, 32'd0);

    // Single pixel capture
    do_arm();
    chk("arm_busy", {31'h0, busy}, 32'd1);
    drive(72, 52, 24'hFF0000); tick();
    chk("p1_count", {23'h0, count}, 32'd1);
    chk("p1_busy",  {31'h0, busy}, 32'd1);
    rd_chk("p1_rd", 8'h00, 24'hFF0000);

    // Full raster, colour = {0, Y, X}
    do_arm();
    for (int y = 52; y < 68; y++)
      for (int x = 72; x < 88; x++) begin
        VGA_X = 8'(x); VGA_Y = 7'(y);
        VGA_COLOR = {8'h0, 8'(y), 8'(x)};
        plot = 1'b1;
        tick();
      end
    plot = 1'b0;
    chk("ras_cnt255", {23'h0, count}, 32'd255);
    chk("ras_busy1",  {31'h0, busy}, 32'd1);
    tick();
    chk("ras_cnt256", {23'h0, count}, 32'd256);
    chk("ras_done",   {31'h0, done}, 32'd1);
    chk("ras_busy0",  {31'h0, busy}, 32'd0);
    for (int a = 0; a < 256; a++)
      rd_chk("ras_rd", 8'(a), {8'h0, 8'(52 + a / 16), 8'(72 + a % 16)});

    // Plot after DONE is dropped
    drive(72, 52, 24'h0000FF); tick();
    chk("dn_count", {23'h0, count}, 32'd256);
    chk("dn_done",  {31'h0, done}, 32'd1);
    rd_chk("dn_rd", 8'h00, 24'h003448);

    // Arm with a pixel in the arm cycle: discarded
    VGA_X = 8'd73; VGA_Y = 7'd52; VGA_COLOR = 24'hABCDEF; plot = 1'b1;
    do_arm();
    plot = 1'b0;
    tick();
    chk("rearm_count", {23'h0, count}, 32'd0);
    chk("rearm_done",  {31'h0, done}, 32'd0);
    chk("rearm_busy",  {31'h0, busy}, 32'd1);
    rd_chk("rearm_rd", 8'h01, 24'h003449);

    // Window edges: only (87,67) is inside
    drive(87, 67, 24'h00FF00);
    drive(71, 52, 24'h123456);
    drive(88, 67, 24'h123456);
    drive(72, 51, 24'h123456);
    drive(72, 68, 24'h123456);
    tick();
    chk("edge_count", {23'h0, count}, 32'd1);
    rd_chk("edge_ff", 8'hFF, 24'h00FF00);
    rd_chk("edge_0f", 8'h0F, 24'h003457);
    rd_chk("edge_f0", 8'hF0, 24'h004348);
    rd_chk("edge_00", 8'h00, 24'h003448);

    // Same address twice: overwrite without recount
    do_arm();
    drive(77, 55, 24'hAAAAAA);
    drive(77, 55, 24'h555555);
    tick();
    chk("dup_count", {23'h0, count}, 32'd1);
    rd_chk("dup_rd", 8'h35, 24'h555555);

    // Arm while a pixel sits in stage 1: written but not counted
    drive(78, 56, 24'h13579B);
    do_arm();
    tick();
    chk("s1arm_count", {23'h0, count}, 32'd0);
    rd_chk("s1arm_rd", 8'h46, 24'h13579B);

    // Async reset mid-capture at count=100
    do_arm();
    for (int i = 0; i < 100; i++) begin
      VGA_X = 8'(72 + i % 16); VGA_Y = 7'(52 + i / 16);
      VGA_COLOR = 24'(i); plot = 1'b1;
      tick();
    end
    plot = 1'b0;
    tick();
    chk("mid_count", {23'h0, count}, 32'd100);
    #2;
    Resetn = 1'b0;
    #1;
    chk("ar_busy",  {31'h0, busy}, 32'd0);
    chk("ar_done",  {31'h0, done}, 32'd0);
    chk("ar_count", {23'h0, count}, 32'd0);
    chk("ar_rd",    {8'h0, rd_data}, 32'd0);
    #3;
    Resetn = 1'b1;
    rd_chk("ar_mem", 8'd99, 24'd99);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/object_capture.md
Name: object_capture

Overview:
- Receive-side counterpart of the object-to-VGA path.
- Snoops the pixel-plot bus (VGA_X, VGA_Y, VGA_COLOR, plot) and captures every pixel plotted inside a 16x16 window into an internal 256x24 object memory.
- Memory address is {y,x}.
- Provides an arm/busy/done handshake, a distinct-pixel count, and a synchronous read port so a checker or second display path can read the captured object back.

Parameters:
- n, 8, VGA_X width; VGA_Y width is n-1.
- XOFFSET, 72, window left column.
- YOFFSET, 52, window top row.

Ports:
- CLOCK_50  input  1  system clock, all logic on rising edge.
- Resetn  input  1  asynchronous active-low reset.
- VGA_X  input  n  plotted column.
- VGA_Y  input  n-1  plotted row.
- VGA_COLOR  input  24  plotted pixel colour.
- plot  input  1  pixel valid, sampled every cycle.
- arm  input  1  single-cycle request: clear and start capture.
- rd_address  input  8  read address {ry[3:0],rx[3:0]}.
- rd_data  output  24  read data, 1-cycle latency.
- busy  output  1  high while in CAPTURE.
- done  output  1  high once all 256 window pixels have been written.
- count  output  9  number of distinct window addresses written, 0..256.

Behaviour:
- Reset (Resetn=0, asynchronous):
  - state=IDLE; busy=0, done=0, count=0, rd_data=0.
  - 256-bit written-map cleared; input pipeline valid cleared.
  - Memory contents are not reset.
- States and transitions:
  - IDLE: arm=1 -> CAPTURE.
  - CAPTURE: arm=1 -> CAPTURE (restart). Otherwise count reaching 256 -> DONE.
  - DONE: arm=1 -> CAPTURE. Otherwise stay in DONE.
- Arm action (any state): at the edge where arm=1 is sampled, count<=0, written-map<=0, done<=0, state<=CAPTURE.
- busy = (state==CAPTURE). done = (state==DONE). Both are registered state decodes.
- Window test:
  - inwin = VGA_X>=XOFFSET && VGA_X<XOFFSET+16 && VGA_Y>=YOFFSET && VGA_Y<YOFFSET+16.
  - Compare at n+1 bits so XOFFSET+16 cannot wrap.
  - lx = (VGA_X-XOFFSET)[3:0]; ly = (VGA_Y-YOFFSET)[3:0].
- Acceptance: a sample is accepted at edge k iff plot=1, inwin=1, state==CAPTURE and arm=0 in that cycle. Samples coinciding with arm are discarded.
- Pipeline stage 1 (edge k): register {ly,lx}, colour and a valid bit.
- Pipeline stage 2 (edge k+1): if valid, write mem[{ly,lx}]<=colour.
  - If the written-map bit for that address is 0: set it and count<=count+1.
  - If the bit is 1: overwrite the data; count is unchanged.
- Completion: when count goes 255->256 at edge k+1, state becomes DONE at that same edge (next-state from count+1). From then on:
  - done=1, busy=0.
  - Further accepted samples are dropped (accept requires CAPTURE).
  - A sample already in stage 1 when DONE is entered is still written to memory, with no count change.
- Arm with a pixel in stage 1: the stage-1 sample is written to memory but does not set the map or count (map/count clear has priority).
- Out-of-window or plot=0 cycles: no effect.
- Read port:
  - rd_data<=mem[rd_address] on every edge, in any state.
  - Latency 1 cycle.
  - A read and a write to the same address at the same edge return the old data.
- count saturates at 256 by construction; there is never a 257th distinct write.
- Resetn asserted mid-capture: immediate return to IDLE with all outputs at reset values. The partial image stays in memory, unflagged.

Test Plan:
- Reset, arm, then plot pixel (72,52) colour 0xFF0000 -> two edges later count=1, busy=1. Read addr 0x00 -> rd_data=0xFF0000 one cycle later.
- Arm, plot (87,67) 0x00FF00, (71,52) and (88,67) 0x123456 -> only addr 0xFF written (0x00FF00), count=1. Out-of-window pixels leave memory and count untouched.
- Arm, raster all 256 window pixels with colour={8'h0,y,x}, plot=1 continuously -> count=256, done=1, busy=0 two edges after the last pixel. Readback of every address matches.
- In CAPTURE, plot addr 0x35 twice (0xAAAAAA then 0x555555) -> count=1, rd_data=0x555555.
- After DONE, plot (72,52) 0x0000FF -> no change. Then arm -> count=0, done=0, busy=1. Pixel sampled in the arm cycle is not counted.
- Mid-capture with count=100, drive Resetn=0 asynchronously between edges -> busy=0, done=0, count=0 immediately, before the next clock edge.
